student_stream_mux: RTL
=======================

Name: student_stream_mux

Overview:
Parametrised N-channel registered multiplexer with valid/ready handshakes on every input and on the output. It is the clocked successor to the 2:1 combinational mux. Two selection modes:
- fixed select, driven by `sel`;
- round-robin among valid channels.

It sits between multiple producer streams and a single consumer. It emits one registered word per transfer, tagged with the source channel number.

Parameters:
WIDTH, 8, data bits per channel
CHANNELS, 4, number of input channels (2..16)
SEL_W, 2, select/channel-index width; must equal max(1, ceil(log2(CHANNELS)))

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  SEL_W  channel index used when mode=0
in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel valid
in_ready  output  CHANNELS  per-channel ready (combinational)
out_data  output  WIDTH  registered output word
out_valid  output  1  output holds a word
out_ready  input  1  consumer accepts out_data this cycle
out_chan  output  SEL_W  channel index of the word in out_data

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset (rst_n=0 at a clock edge):
  - out_valid<=0, out_data<=0, out_chan<=0.
  - Round-robin pointer ptr<=CHANNELS-1, so the first RR search starts at channel 0.
  - While rst_n=0, in_ready is forced to all-zeros.
  - Reset mid-operation discards any held output word; no input transfer occurs in that cycle.
- Load enable: load_en = !out_valid | out_ready. The output register is refilled in the same cycle it is drained, giving full throughput of 1 word/cycle.
- Grant, combinational, evaluated every cycle:
  - mode=0: grant=sel and gnt_ok=in_valid[sel]. If sel>=CHANNELS, gnt_ok=0 and no channel is ever granted.
  - mode=1: scan channels ptr+1, ptr+2, … modulo CHANNELS. Grant the first one with in_valid=1. gnt_ok=0 if no input is valid.
- in_ready[i] = rst_n & load_en & gnt_ok & (grant==i). At most one bit is set. Input channel i transfers when in_valid[i] & in_ready[i].
- On a clock edge with rst_n=1 and load_en=1:
  - If gnt_ok: out_data<=in_data[grant], out_chan<=grant, out_valid<=1, ptr<=grant. ptr updates in both modes.
  - Otherwise: out_valid<=0. out_data and out_chan hold their old values.
- On a clock edge with load_en=0 (stall: out_valid=1, out_ready=0): all outputs and ptr hold. in_ready is all-zeros.
- Latency: 1 cycle from input transfer to out_valid=1 with that word.
- Data order: words are never dropped or duplicated. The order within a channel is preserved.
- Mode or sel changes:
  - They affect only the grant decision of the current cycle.
  - An already-registered output word is unaffected.
  - Switching to mode=1 resumes from the current ptr.
- Fairness in mode=1: with all channels continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0,… There are no repeats within a lap.
- Simultaneous drain and fill: when out_valid=1, out_ready=1 and gnt_ok=1, the old word is consumed and the new word is loaded on the same edge. out_valid stays 1.

Test Plan (WIDTH=8, CHANNELS=4):
- Reset and fixed mode: hold rst_n=0 for 2 cycles, then release. Set mode=0, sel=2, in_valid=4'b0100, channel 2 data=8'hA5, out_ready=1.
  - During reset: in_ready=0 and out_valid=0.
  - Cycle after release: in_ready=4'b0100.
  - Next cycle: out_valid=1, out_data=8'hA5, out_chan=2.
- Round-robin fairness: mode=1, in_valid=4'b1111, channel i data=8'h10+i, out_ready=1 for 8 cycles.
  - out_chan sequence is 0,1,2,3,0,1,2,3.
  - out_data sequence is 10,11,12,13,10,11,12,13 (hex).
- Round-robin skip: mode=1, ptr=0 (after a channel-0 grant), in_valid=4'b1001.
  - Next grant is channel 3, then channel 0.
  - Channels 1 and 2 are never granted.
- Backpressure stall: a word is held at out_data=8'h33, out_chan=1. Drive out_ready=0 for 3 cycles with in_valid=4'b1111.
  - in_ready=0 throughout; outputs hold 8'h33/1.
  - Raise out_ready: the same-cycle refill loads the next RR channel (2) and out_valid stays 1.
- Fixed-mode no-grant: mode=0, sel=1, in_valid=4'b1101.
  - in_ready=0.
  - Once the held word is drained, out_valid falls to 0.
  - Changing sel to 3 grants channel 3 in the same cycle.
- Reset mid-stream: out_valid=1, out_data=8'h77. Assert rst_n=0 for 1 cycle.
  - Next cycle: out_valid=0, out_data=0, out_chan=0.
  - After release in mode=1 with in_valid=4'b1111, the first grant is channel 0.

Source files
------------

// File: rtl/student_stream_mux.sv
// rtl/student_stream_mux.sv - N-channel registered stream mux with fixed-select and round-robin grant
module student_stream_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             gnt_ok;
    logic             load_en;
    logic [WIDTH-1:0] gnt_data;

    assign load_en = !out_valid || out_ready;

    // Round-robin scan runs from the farthest candidate back to ptr+1, so the
    // last hit is the first valid channel after ptr.
    always_comb begin
        grant  = '0;
        gnt_ok = 1'b0;
        if (!mode) begin
            grant = sel;
            if (int'(sel) < CHANNELS) begin
                gnt_ok = in_valid[sel];
            end
        end else begin
            for (int k = CHANNELS; k >= 1; k--) begin
                if (in_valid[(int'(ptr) + k) % CHANNELS]) begin
                    grant  = SEL_W'((int'(ptr) + k) % CHANNELS);
                    gnt_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = rst_n && load_en && gnt_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= SEL_W'(CHANNELS - 1);
        end else if (load_en) begin
            if (gnt_ok) begin
                out_data  <= gnt_data;
                out_chan  <= grant;
                out_valid <= 1'b1;
                ptr       <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
